// File: rtl/gain_stream_mc.sv
// gain_stream_mc: multi-channel back-pressured Q(FRAC_BITS) gain stage between two FWFT FIFOs.
//   clock       rising-edge system clock
//   reset       asynchronous active-low reset; clears FIFOs, pipeline, gains, sat_count
//   in_din/in_wr_en/in_full     input sample push side
//   out_dout/out_chan/out_rd_en/out_empty   gained sample pop side, tagged with channel
//   gain_wr_en/gain_sel/gain_din            run-time per-channel gain write
//   ch_sync     next popped sample is channel 0
//   sat_count   saturating count of clipped results
// Optional: define GAIN_ROUND_EN to round half toward +inf instead of truncating.
module gain_stream_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 10,
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 256,
   parameter int GAIN_INIT  = 1024,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_din,
   input  logic                  in_wr_en,
   output logic                  in_full,
   output logic [DATA_WIDTH-1:0] out_dout,
   output logic [CH_W-1:0]       out_chan,
   input  logic                  out_rd_en,
   output logic                  out_empty,
   input  logic                  gain_wr_en,
   input  logic [CH_W-1:0]       gain_sel,
   input  logic [DATA_WIDTH-1:0] gain_din,
   input  logic                  ch_sync,
   output logic [15:0]           sat_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = 2 * DATA_WIDTH;
`ifdef GAIN_ROUND_EN
   localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC_BITS - 1);
`else
   localparam logic signed [PW-1:0] RND = '0;
`endif
   logic [DATA_WIDTH-1:0]      r_in_mem [FIFO_DEPTH];
   logic [AW-1:0]              r_in_wp, r_in_rp;
   logic [CW-1:0]              r_in_cnt;
   logic                       r_push_d;
   logic [CH_W+DATA_WIDTH-1:0] r_out_mem [FIFO_DEPTH];
   logic [AW-1:0]              r_out_wp, r_out_rp;
   logic [CW-1:0]              r_out_cnt;
   logic [CH_W-1:0]            r_ch;
   logic signed [DATA_WIDTH-1:0] r_gain [CHANNELS];
   logic                       r_s1_v, r_s2_v;
   logic [CH_W-1:0]            r_s1_tag, r_s2_tag;
   logic signed [DATA_WIDTH-1:0] r_s1_d, r_s1_g;
   logic signed [PW-1:0]       r_s2_p;
   logic [15:0]                r_sat;
   logic                       w_in_push, w_in_pop, w_in_empty, w_out_pop, w_clip;
   logic [CH_W-1:0]            w_tag, w_ch_nxt;
   logic signed [PW-1:0]       w_sum, w_shift;
   logic [DATA_WIDTH-1:0]      w_res;
   assign w_in_push  = in_wr_en && !in_full;
   assign in_full    = r_in_cnt == CW'(FIFO_DEPTH);
   // the entry pushed on the last edge is still in the RAM write port, so it is not yet poppable
   assign w_in_empty = r_in_cnt <= CW'(r_push_d);
   // credit check: every in-flight sample already owns an output FIFO slot
   assign w_in_pop   = !w_in_empty && (32'(r_out_cnt) + 32'(r_s1_v) + 32'(r_s2_v) < FIFO_DEPTH);
   assign out_empty  = r_out_cnt == '0;
   assign w_out_pop  = out_rd_en && !out_empty;
   assign {out_chan, out_dout} = out_empty ? '0 : r_out_mem[r_out_rp];
   assign sat_count  = r_sat;
   assign w_tag      = ch_sync ? '0 : r_ch;
   assign w_ch_nxt   = (32'(w_tag) == CHANNELS - 1) ? '0 : w_tag + 1'b1;
   assign w_sum      = r_s2_p + RND;
   assign w_shift    = w_sum >>> FRAC_BITS;
   // result fits only if the bits above the sign bit are pure sign extension
   assign w_clip     = !(&w_shift[PW-1:DATA_WIDTH-1]) && (|w_shift[PW-1:DATA_WIDTH-1]);
   assign w_res      = !w_clip ? w_shift[DATA_WIDTH-1:0] :
                       w_shift[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
   always_ff @(posedge clock) begin
      if (w_in_push) r_in_mem[r_in_wp] <= in_din;
      if (r_s2_v) r_out_mem[r_out_wp] <= {r_s2_tag, w_res};
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_in_wp   <= '0;
         r_in_rp   <= '0;
         r_in_cnt  <= '0;
         r_push_d  <= 1'b0;
         r_out_wp  <= '0;
         r_out_rp  <= '0;
         r_out_cnt <= '0;
         r_ch      <= '0;
         r_s1_v    <= 1'b0;
         r_s1_tag  <= '0;
         r_s1_d    <= '0;
         r_s1_g    <= '0;
         r_s2_v    <= 1'b0;
         r_s2_tag  <= '0;
         r_s2_p    <= '0;
         r_sat     <= '0;
         for (int i = 0; i < CHANNELS; i++) r_gain[i] <= DATA_WIDTH'(GAIN_INIT);
      end else begin
         r_push_d  <= w_in_push;
         r_in_wp   <= r_in_wp + AW'(w_in_push);
         r_in_rp   <= r_in_rp + AW'(w_in_pop);
         r_in_cnt  <= r_in_cnt + CW'(w_in_push) - CW'(w_in_pop);
         r_out_wp  <= r_out_wp + AW'(r_s2_v);
         r_out_rp  <= r_out_rp + AW'(w_out_pop);
         r_out_cnt <= r_out_cnt + CW'(r_s2_v) - CW'(w_out_pop);
         if (w_in_pop) r_ch <= w_ch_nxt;
         else if (ch_sync) r_ch <= '0;
         r_s1_v <= w_in_pop;
         if (w_in_pop) begin
            r_s1_d   <= r_in_mem[r_in_rp];
            r_s1_tag <= w_tag;
            r_s1_g   <= r_gain[w_tag];
         end
         r_s2_v   <= r_s1_v;
         r_s2_tag <= r_s1_tag;
         r_s2_p   <= PW'(r_s1_d) * PW'(r_s1_g);
         if (r_s2_v && w_clip && r_sat != 16'hFFFF) r_sat <= r_sat + 16'd1;
         if (gain_wr_en && 32'(gain_sel) < CHANNELS) r_gain[gain_sel] <= gain_din;
      end
   end
endmodule

// File: tb/tb_gain_stream_mc.sv
// tb_gain_stream_mc: self-checking bench for gain_stream_mc (vector table, directed corners, random vs. model).
module tb_gain_stream_mc;
   localparam int FB = 10;
`ifdef GAIN_ROUND_EN
   localparam bit RND = 1;
`else
   localparam bit RND = 0;
`endif
   typedef struct { int g0; int g1; int x0; int x1; int e0; int e1; int sat; } vec_t;
   typedef struct { logic [31:0] d; logic c; } exp_t;
   logic        clock, reset, in_wr_en, in_full, out_rd_en, out_empty, gain_wr_en, ch_sync;
   logic [31:0] in_din, out_dout, gain_din;
   logic        out_chan, gain_sel;
   logic [15:0] sat_count;
   int          n_vec, n_bad, exp_sat;
   exp_t        q[$];
   vec_t        tbl[7];
   gain_stream_mc dut (
      .clock(clock), .reset(reset), .in_din(in_din), .in_wr_en(in_wr_en), .in_full(in_full),
      .out_dout(out_dout), .out_chan(out_chan), .out_rd_en(out_rd_en), .out_empty(out_empty),
      .gain_wr_en(gain_wr_en), .gain_sel(gain_sel), .gain_din(gain_din), .ch_sync(ch_sync),
      .sat_count(sat_count)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   function automatic logic [31:0] ref_gain(input int x, input int g, output bit clip);
      longint p;
      p = longint'(x) * longint'(g);
      if (RND) p = p + (64'sd1 <<< (FB - 1));
      p = p >>> FB;
      clip = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      return clip ? (p > 0 ? 32'h7FFFFFFF : 32'h80000000) : 32'(p);
   endfunction
   task automatic set_gain(input logic ch, input int g);
      gain_sel = ch;
      gain_din = g;
      gain_wr_en = 1'b1;
      tick;
      gain_wr_en = 1'b0;
   endtask
   task automatic sync_idle;
      ch_sync = 1'b1;
      tick;
      ch_sync = 1'b0;
   endtask
   task automatic put(input int x);
      in_din = x;
      in_wr_en = 1'b1;
      tick;
      in_wr_en = 1'b0;
   endtask
   task automatic wait_out(input string nm);
      int k = 0;
      while (out_empty && k < 100) begin
         tick;
         k++;
      end
      if (out_empty) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: output still empty after %0d cycles", nm, k);
      end
   endtask
   task automatic pop_chk(input string nm, input logic [31:0] d, input logic c);
      wait_out(nm);
      chk({nm, "_data"}, out_dout, d);
      chk({nm, "_chan"}, 32'(out_chan), 32'(c));
      out_rd_en = 1'b1;
      tick;
      out_rd_en = 1'b0;
   endtask
   initial begin
      tbl[0] = '{1024, 1024, 1000, -1000, 1000, -1000, 0};
      tbl[1] = '{2048, 512, 100, 100, 200, 50, 0};
      tbl[2] = '{2048, 512, -7, -7, -14, RND ? -3 : -4, 0};
      tbl[3] = '{4096, 4096, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 2};
      tbl[4] = '{-1024, -1024, 32'h80000000, 5, 32'h7FFFFFFF, -5, 1};
      tbl[5] = '{1, 1, 1023, -1, RND ? 1 : 0, RND ? 0 : -1, 0};
      tbl[6] = '{0, 1536, 12345, 3, 0, RND ? 5 : 4, 0};
      n_vec = 0; n_bad = 0; exp_sat = 0;
      reset = 1'b0; in_wr_en = 1'b0; out_rd_en = 1'b0; gain_wr_en = 1'b0; ch_sync = 1'b0;
      in_din = '0; gain_din = '0; gain_sel = 1'b0;
      repeat (3) tick;
      chk("rst_in_full", 32'(in_full), 0);
      chk("rst_out_empty", 32'(out_empty), 1);
      chk("rst_out_dout", out_dout, 0);
      chk("rst_out_chan", 32'(out_chan), 0);
      chk("rst_sat", 32'(sat_count), 0);
      reset = 1'b1;
      tick;
      // latency: first write at edge t, output must appear right after edge t+4
      in_din = 1000; in_wr_en = 1'b1; tick;
      in_din = -1000; tick;
      in_wr_en = 1'b0;
      chk("lat_t1", 32'(out_empty), 1);
      tick; chk("lat_t2", 32'(out_empty), 1);
      tick; chk("lat_t3", 32'(out_empty), 1);
      tick; chk("lat_t4", 32'(out_empty), 0);
      pop_chk("unity0", 1000, 1'b0);
      pop_chk("unity1", -1000, 1'b1);
      for (int i = 0; i < 7; i++) begin
         set_gain(1'b0, tbl[i].g0);
         set_gain(1'b1, tbl[i].g1);
         sync_idle;
         put(tbl[i].x0);
         put(tbl[i].x1);
         pop_chk($sformatf("tbl%0d_a", i), tbl[i].e0, 1'b0);
         pop_chk($sformatf("tbl%0d_b", i), tbl[i].e1, 1'b1);
         exp_sat += tbl[i].sat;
         chk($sformatf("tbl%0d_sat", i), 32'(sat_count), 32'(exp_sat));
      end
      // ch_sync on the pop of the second sample (edge t+3), then ch0 gain forced to 0
      set_gain(1'b0, 1024);
      set_gain(1'b1, 1024);
      sync_idle;
      in_wr_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_din = 11 * (k + 1);
         ch_sync = (k == 3);
         tick;
      end
      in_wr_en = 1'b0; ch_sync = 1'b0;
      pop_chk("sync_a", 11, 1'b0);
      pop_chk("sync_b", 22, 1'b0);
      pop_chk("sync_c", 33, 1'b1);
      pop_chk("sync_d", 44, 1'b0);
      pop_chk("sync_e", 55, 1'b1);
      set_gain(1'b0, 0);
      put(66);
      put(77);
      pop_chk("g0zero_a", 0, 1'b0);
      pop_chk("g0zero_b", 77, 1'b1);
      // back-pressure: output blocked, fill until in_full
      set_gain(1'b0, 1024);
      sync_idle;
      begin
         int acc = 0;
         for (int i = 0; i < 600; i++) begin
            if (in_full) break;
            in_din = 5000 + i; in_wr_en = 1'b1; tick;
            acc++;
         end
         in_wr_en = 1'b0;
         repeat (10) tick;
         chk("bp_in_full", 32'(in_full), 1);
         chk("bp_accepted", acc, 512);
         for (int i = 0; i < acc; i++) pop_chk("bp_drain", 5000 + i, i[0]);
         repeat (10) tick;
         chk("bp_empty_after", 32'(out_empty), 1);
      end
      // random rounds against the arithmetic model
      for (int r = 0; r < 40; r++) begin
         int g[2];
         int left, cnt, cyc;
         bit clip;
         for (int c = 0; c < 2; c++) begin
            g[c] = int'($urandom_range(0, 8192)) - 4096;
            if ($urandom_range(0, 4) == 0) g[c] = int'($urandom);
            set_gain(c[0], g[c]);
         end
         sync_idle;
         left = int'($urandom_range(1, 30));
         cnt = 0; cyc = 0;
         while ((left > 0 || q.size() > 0) && cyc < 3000) begin
            in_wr_en = 1'b0;
            if (left > 0 && !in_full && $urandom_range(0, 3) != 0) begin
               int x;
               exp_t e;
               x = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 20000)) - 10000;
               e.c = cnt[0];
               e.d = ref_gain(x, g[cnt % 2], clip);
               if (clip && exp_sat < 16'hFFFF) exp_sat++;
               q.push_back(e);
               in_din = x; in_wr_en = 1'b1;
               left--; cnt++;
            end
            out_rd_en = $urandom_range(0, 2) != 0;
            if (out_rd_en && !out_empty) begin
               exp_t e;
               e = q.pop_front();
               chk($sformatf("rnd%0d_data", r), out_dout, e.d);
               chk($sformatf("rnd%0d_chan", r), 32'(out_chan), 32'(e.c));
            end
            tick;
            cyc++;
         end
         in_wr_en = 1'b0; out_rd_en = 1'b0;
         if (cyc >= 3000) begin
            n_vec++; n_bad++;
            $display("FAIL rnd%0d_timeout: %0d results still outstanding", r, q.size());
            q.delete();
         end
         chk($sformatf("rnd%0d_sat", r), 32'(sat_count), 32'(exp_sat));
      end
      // reset mid-operation with both FIFOs loaded and non-default gain
      set_gain(1'b0, 3072);
      sync_idle;
      for (int i = 0; i < 600; i++) begin
         if (in_full) break;
         in_din = i; in_wr_en = 1'b1; tick;
      end
      in_wr_en = 1'b0;
      repeat (5) tick;
      chk("pre_rst_full", 32'(in_full), 1);
      #3 reset = 1'b0;
      #1;
      chk("arst_in_full", 32'(in_full), 0);
      chk("arst_out_empty", 32'(out_empty), 1);
      chk("arst_out_dout", out_dout, 0);
      chk("arst_sat", 32'(sat_count), 0);
      tick;
      reset = 1'b1;
      exp_sat = 0;
      tick;
      put(777);
      put(-777);
      pop_chk("post_rst_a", 777, 1'b0);
      pop_chk("post_rst_b", -777, 1'b1);
      repeat (20) tick;
      chk("post_rst_no_stale", 32'(out_empty), 1);
      chk("post_rst_sat", 32'(sat_count), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
